// File: rtl/map_pkg.sv
// Shared types for the map difference scanner: object codes, FSM states,
// default playfield size and the object-flag priority encoder.
package map_pkg;

  localparam int DEF_GRID_W = 16;
  localparam int DEF_GRID_H = 12;

  typedef enum logic [2:0] {
    OBJ_EMPTY  = 3'd0,
    OBJ_HEAD   = 3'd1,
    OBJ_BODY   = 3'd2,
    OBJ_APPLE  = 3'd3,
    OBJ_BORDER = 3'd4
  } obj_code_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_UPDATE,
    ST_ABORT,
    ST_DONE
  } state_t;

  // Overlapping flags resolve head > body > apple > border.
  function automatic obj_code_t encode_obj(input logic head, input logic body,
                                           input logic apple, input logic border);
    obj_code_t code;
    if (head)        code = OBJ_HEAD;
    else if (body)   code = OBJ_BODY;
    else if (apple)  code = OBJ_APPLE;
    else if (border) code = OBJ_BORDER;
    else             code = OBJ_EMPTY;
    return code;
  endfunction

endpackage

// File: rtl/map_shadow_ram.sv
// Shadow copy of the last drawn frame: one object code per cell,
// combinational read, synchronous write, index y*GRID_W+x.
module map_shadow_ram #(
  parameter int DEPTH  = 192,
  parameter int CODE_W = 3,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [CODE_W-1:0] wdata,
  output logic [CODE_W-1:0] rdata
);

  logic [CODE_W-1:0] mem [DEPTH];

  // No reset: contents are irrelevant until a forced full refresh rewrites them.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/map_diff_scanner.sv
// Raster-scans the playfield once per frame_tick, compares each cell's object
// code with the shadow frame and requests a draw only where it changed.
module map_diff_scanner
  import map_pkg::*;
#(
  parameter int GRID_W = DEF_GRID_W,
  parameter int GRID_H = DEF_GRID_H,
  parameter int X_W    = $clog2(GRID_W),
  parameter int Y_W    = $clog2(GRID_H),
  parameter int CODE_W = 3
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              frame_tick,
  input  logic              snake_head,
  input  logic              snake_body,
  input  logic              apple,
  input  logic              border,
  input  logic              full_refresh,
  input  logic              game_over,
  input  logic              mode_pb,
  input  logic              cmd_done,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic [CODE_W-1:0] obj_code,
  output logic              en_update,
  output logic              busy,
  output logic              init_cycle,
  output logic              frame_done,
  output logic              sync_reset,
  output logic              frame_overrun
);

  localparam int CELLS  = GRID_W * GRID_H;
  localparam int ADDR_W = $clog2(CELLS);

  // Draw handshake: en_update rises with x/y/obj_code stable and all three
  // hold until the cycle cmd_done is sampled high; en_update then drops for
  // at least one cycle before the next request.
  state_t            state;
  logic              refresh_frame;
  logic              abort_pend;
  logic              game_over_q;
  logic              mode_pb_q;
  logic              abort_edge;
  logic              last_cell;
  logic              changed;
  logic              shadow_we;
  obj_code_t         enc;
  logic [CODE_W-1:0] code;
  logic [CODE_W-1:0] shadow_code;
  logic [ADDR_W-1:0] addr;
  logic [X_W-1:0]    x_adv;
  logic [Y_W-1:0]    y_adv;

  assign abort_edge = (game_over & ~game_over_q) | (mode_pb & ~mode_pb_q);
  assign enc        = encode_obj(snake_head, snake_body, apple, border);
  assign code       = CODE_W'(enc);
  assign addr       = ADDR_W'(int'(y) * GRID_W + int'(x));
  assign last_cell  = (x == X_W'(GRID_W - 1)) && (y == Y_W'(GRID_H - 1));
  assign changed    = refresh_frame || (code != shadow_code);
  assign shadow_we  = (state == ST_SCAN) && !abort_edge && changed;
  assign busy       = (state != ST_IDLE);

  always_comb begin
    x_adv = x + X_W'(1);
    y_adv = y;
    if (x == X_W'(GRID_W - 1)) begin
      x_adv = '0;
      y_adv = y + Y_W'(1);
    end
  end

  map_shadow_ram #(
    .DEPTH (CELLS),
    .CODE_W(CODE_W),
    .ADDR_W(ADDR_W)
  ) u_shadow (
    .clk  (clk),
    .addr (addr),
    .we   (shadow_we),
    .wdata(code),
    .rdata(shadow_code)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state         <= ST_IDLE;
      x             <= '0;
      y             <= '0;
      obj_code      <= '0;
      en_update     <= 1'b0;
      frame_done    <= 1'b0;
      sync_reset    <= 1'b0;
      frame_overrun <= 1'b0;
      init_cycle    <= 1'b1;
      refresh_frame <= 1'b0;
      abort_pend    <= 1'b0;
      game_over_q   <= 1'b0;
      mode_pb_q     <= 1'b0;
    end else begin
      game_over_q   <= game_over;
      mode_pb_q     <= mode_pb;
      frame_done    <= 1'b0;
      sync_reset    <= 1'b0;
      frame_overrun <= frame_tick && (state != ST_IDLE);

      case (state)
        ST_IDLE: begin
          if (abort_edge) begin
            state      <= ST_ABORT;
            sync_reset <= 1'b1;
          end else if (frame_tick) begin
            state         <= ST_SCAN;
            x             <= '0;
            y             <= '0;
            refresh_frame <= init_cycle | full_refresh;
          end
        end

        ST_SCAN: begin
          if (abort_edge) begin
            state      <= ST_ABORT;
            sync_reset <= 1'b1;
            x          <= '0;
            y          <= '0;
          end else if (changed) begin
            obj_code  <= code;
            en_update <= 1'b1;
            state     <= ST_UPDATE;
          end else if (last_cell) begin
            state <= ST_DONE;
          end else begin
            x <= x_adv;
            y <= y_adv;
          end
        end

        // An abort seen mid-command is parked until the engine acknowledges.
        ST_UPDATE: begin
          if (cmd_done) begin
            en_update  <= 1'b0;
            abort_pend <= 1'b0;
            if (abort_pend || abort_edge) begin
              state      <= ST_ABORT;
              sync_reset <= 1'b1;
              x          <= '0;
              y          <= '0;
            end else if (last_cell) begin
              state <= ST_DONE;
            end else begin
              state <= ST_SCAN;
              x     <= x_adv;
              y     <= y_adv;
            end
          end else if (abort_edge) begin
            abort_pend <= 1'b1;
          end
        end

        ST_DONE: begin
          x <= '0;
          y <= '0;
          if (abort_edge) begin
            state      <= ST_ABORT;
            sync_reset <= 1'b1;
          end else begin
            state      <= ST_IDLE;
            frame_done <= 1'b1;
            if (refresh_frame) init_cycle <= 1'b0;
          end
        end

        ST_ABORT: begin
          state <= ST_IDLE;
          x     <= '0;
          y     <= '0;
        end

        default: state <= ST_IDLE;
      endcase

      // Placed last so an abort edge outranks the end-of-refresh clear in DONE.
      if (abort_edge) init_cycle <= 1'b1;
    end
  end

endmodule

// File: tb/tb_map_diff_scanner.sv
// Scoreboard bench for map_diff_scanner: expected draw requests are queued
// per frame and popped by a monitor on every new en_update request.
module tb_map_diff_scanner;

  localparam int GW = 16;
  localparam int GH = 12;
  localparam int XW = 4;
  localparam int YW = 4;
  localparam int CW = 3;
  localparam int EW = XW + YW + CW;

  logic          clk = 1'b0;
  logic          nrst;
  logic          frame_tick;
  logic          snake_head, snake_body, apple, border;
  logic          full_refresh, game_over, mode_pb, cmd_done;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [CW-1:0] obj_code;
  logic          en_update, busy, init_cycle, frame_done, sync_reset, frame_overrun;

  // Scene maps indexed {y,x}, i.e. y*16+x.
  logic head_m   [256];
  logic body_m   [256];
  logic apple_m  [256];
  logic border_m [256];

  assign snake_head = head_m[{y, x}];
  assign snake_body = body_m[{y, x}];
  assign apple      = apple_m[{y, x}];
  assign border     = border_m[{y, x}];

  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int req_cnt  = 0;
  int done_cnt = 0;
  int ovr_cnt  = 0;
  int sync_cnt = 0;
  int cmd_delay = 3;

  map_diff_scanner dut (
    .clk          (clk),
    .nrst         (nrst),
    .frame_tick   (frame_tick),
    .snake_head   (snake_head),
    .snake_body   (snake_body),
    .apple        (apple),
    .border       (border),
    .full_refresh (full_refresh),
    .game_over    (game_over),
    .mode_pb      (mode_pb),
    .cmd_done     (cmd_done),
    .x            (x),
    .y            (y),
    .obj_code     (obj_code),
    .en_update    (en_update),
    .busy         (busy),
    .init_cycle   (init_cycle),
    .frame_done   (frame_done),
    .sync_reset   (sync_reset),
    .frame_overrun(frame_overrun)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] scene_code(input int cx, input int cy);
    int i;
    i = cy * GW + cx;
    if (head_m[i])        return 3'd1;
    else if (body_m[i])   return 3'd2;
    else if (apple_m[i])  return 3'd3;
    else if (border_m[i]) return 3'd4;
    return 3'd0;
  endfunction

  function automatic logic [EW-1:0] pack_req(input int cx, input int cy, input int c);
    logic [XW-1:0] px;
    logic [YW-1:0] py;
    logic [CW-1:0] pc;
    px = XW'(cx);
    py = YW'(cy);
    pc = CW'(c);
    return {px, py, pc};
  endfunction

  task automatic push_full_frame();
    for (int cy = 0; cy < GH; cy++)
      for (int cx = 0; cx < GW; cx++)
        exp_q.push_back(pack_req(cx, cy, int'(scene_code(cx, cy))));
  endtask

  // Display-engine responder: acknowledges each request cmd_delay cycles later.
  initial begin
    cmd_done = 1'b0;
    forever begin
      @(negedge clk);
      if (en_update && nrst) begin
        repeat (cmd_delay - 1) @(negedge clk);
        cmd_done = 1'b1;
        @(negedge clk);
        cmd_done = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on each new request, counts output pulses.
  initial begin
    logic en_prev;
    logic [EW-1:0] e;
    en_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (en_update && !en_prev) begin
        req_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL request_unexpected: actual x=%0d y=%0d code=%0d required none", x, y, obj_code);
        end else begin
          e = exp_q.pop_front();
          n_checks++;
          if ({x, y, obj_code} !== e) begin
            n_fail++;
            $display("FAIL request: actual x=%0d y=%0d code=%0d required x=%0d y=%0d code=%0d",
                     x, y, obj_code, e[EW-1 -: XW], e[CW+YW-1 -: YW], e[CW-1:0]);
          end
        end
      end
      if (frame_done)    done_cnt++;
      if (frame_overrun) ovr_cnt++;
      if (sync_reset)    sync_cnt++;
      en_prev = en_update;
    end
  end

  // Driver: one frame, optional second frame_tick at cycle ovr_at; lat is the
  // number of rising edges from the one sampling frame_tick to frame_done.
  task automatic run_frame(input int ovr_at, output int lat);
    int cnt;
    @(negedge clk);
    frame_tick = 1'b1;
    @(posedge clk);
    cnt = 1;
    forever begin
      @(negedge clk);
      frame_tick = (cnt == ovr_at);
      if (frame_done) break;
      if (cnt > 3000) begin
        check("frame_done_timeout", 32'(cnt), 32'd0);
        break;
      end
      @(posedge clk);
      cnt++;
    end
    frame_tick = 1'b0;
    lat = cnt;
  endtask

  initial begin
    int lat;
    int r0, d0, o0;
    bit got;

    for (int i = 0; i < 256; i++) begin
      head_m[i] = 0; body_m[i] = 0; apple_m[i] = 0; border_m[i] = 0;
    end
    for (int cy = 0; cy < GH; cy++)
      for (int cx = 0; cx < GW; cx++)
        if (cx == 0 || cy == 0 || cx == GW - 1 || cy == GH - 1) border_m[cy * GW + cx] = 1;
    head_m[4 * GW + 4]  = 1;
    apple_m[4 * GW + 6] = 1;

    nrst = 1'b0; frame_tick = 1'b0; full_refresh = 1'b0; game_over = 1'b0; mode_pb = 1'b0;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_x", 32'(x), 32'd0);
    check("reset_y", 32'(y), 32'd0);
    check("reset_init_cycle", 32'(init_cycle), 32'd1);
    check("reset_en_update", 32'(en_update), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_obj_code", 32'(obj_code), 32'd0);
    check("reset_pulses", 32'({frame_done, sync_reset, frame_overrun}), 32'd0);

    // Frame 1: forced full refresh of the whole scene.
    push_full_frame();
    r0 = req_cnt; d0 = done_cnt;
    run_frame(-1, lat);
    @(negedge clk);
    check("f1_requests", 32'(req_cnt - r0), 32'd192);
    check("f1_frame_done", 32'(done_cnt - d0), 32'd1);
    check("f1_init_cleared", 32'(init_cycle), 32'd0);
    check("f1_queue_empty", 32'(exp_q.size()), 32'd0);
    check("f1_busy_after", 32'(busy), 32'd0);

    // Frame 2: identical scene, no draws, fixed latency.
    r0 = req_cnt;
    run_frame(-1, lat);
    check("f2_latency", 32'(lat), 32'd194);
    check("f2_requests", 32'(req_cnt - r0), 32'd0);

    // Frame 3: head moves right, body left behind.
    head_m[4 * GW + 4] = 0;
    body_m[4 * GW + 4] = 1;
    head_m[4 * GW + 5] = 1;
    exp_q.push_back(pack_req(4, 4, 2));
    exp_q.push_back(pack_req(5, 4, 1));
    r0 = req_cnt;
    run_frame(-1, lat);
    check("f3_requests", 32'(req_cnt - r0), 32'd2);

    // Frame 4: head and body overlap at (7,4), head wins.
    head_m[4 * GW + 7] = 1;
    body_m[4 * GW + 7] = 1;
    exp_q.push_back(pack_req(7, 4, 1));
    r0 = req_cnt;
    run_frame(-1, lat);
    check("f4_requests", 32'(req_cnt - r0), 32'd1);

    // Frame 5: second frame_tick mid-scan is flagged and otherwise ignored.
    r0 = req_cnt; o0 = ovr_cnt;
    run_frame(40, lat);
    @(negedge clk);
    check("f5_overrun_pulses", 32'(ovr_cnt - o0), 32'd1);
    check("f5_latency", 32'(lat), 32'd194);
    check("f5_requests", 32'(req_cnt - r0), 32'd0);

    // Frame 6: apple moves, game_over rises during the first draw command.
    apple_m[4 * GW + 6] = 0;
    apple_m[4 * GW + 8] = 1;
    exp_q.push_back(pack_req(6, 4, 0));
    cmd_delay = 10;
    d0 = done_cnt;
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    got = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (en_update) begin got = 1; break; end
    end
    check("f6_request_seen", 32'(got), 32'd1);
    game_over = 1'b1;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      check("f6_en_update_held", 32'(en_update), 32'd1);
      if (cmd_done) begin got = 1; break; end
    end
    check("f6_cmd_done_seen", 32'(got), 32'd1);
    @(negedge clk); #1;
    check("f6_sync_reset_pulse", 32'(sync_reset), 32'd1);
    check("f6_init_cycle_set", 32'(init_cycle), 32'd1);
    check("f6_en_update_dropped", 32'(en_update), 32'd0);
    @(negedge clk); #1;
    check("f6_sync_reset_one_cycle", 32'(sync_reset), 32'd0);
    check("f6_busy_idle", 32'(busy), 32'd0);
    check("f6_no_frame_done", 32'(done_cnt - d0), 32'd0);
    check("f6_queue_empty", 32'(exp_q.size()), 32'd0);
    game_over = 1'b0;
    cmd_delay = 3;
    repeat (2) @(negedge clk);

    // Frame 7: resynchronised full refresh of the current scene.
    push_full_frame();
    r0 = req_cnt;
    run_frame(-1, lat);
    @(negedge clk);
    check("f7_requests", 32'(req_cnt - r0), 32'd192);
    check("f7_init_cleared", 32'(init_cycle), 32'd0);
    check("f7_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/map_diff_scanner.md
Name: map_diff_scanner

Overview:
- Parametrised successor to the current 16x12 map scanner.
- Walks every cell of a GRID_W x GRID_H playfield once per frame_tick and priority-encodes the object flags supplied by game logic into an object code.
- Compares each code against an internal shadow copy of the last drawn frame. Requests a display-engine draw, via an en_update/cmd_done handshake, only for cells that changed, or for every cell when a full refresh is due.
- Sits between the game-state logic and the display command engine.

Parameters:
- GRID_W, 16, playfield columns (>=2).
- GRID_H, 12, playfield rows (>=2).
- X_W, $clog2(GRID_W), width of x coordinate.
- Y_W, $clog2(GRID_H), width of y coordinate.
- CODE_W, 3, object code width (>=3).

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- frame_tick  in  1  single-cycle pulse; start of a new scan
- snake_head  in  1  object flag for current (x,y), valid combinationally in the same cycle
- snake_body  in  1  object flag for current (x,y)
- apple  in  1  object flag for current (x,y)
- border  in  1  object flag for current (x,y)
- full_refresh  in  1  level; forces every cell of the next-started frame to be drawn
- game_over  in  1  level; rising edge aborts and resynchronises
- mode_pb  in  1  synchronised button level; rising edge aborts and resynchronises
- cmd_done  in  1  display engine finished the current draw command
- x  out  X_W  current column
- y  out  Y_W  current row
- obj_code  out  CODE_W  code latched for the requested draw
- en_update  out  1  draw request, held until cmd_done
- busy  out  1  high in any state other than IDLE
- init_cycle  out  1  high while the next or current frame is a forced full refresh
- frame_done  out  1  one-cycle pulse at end of a completed frame
- sync_reset  out  1  one-cycle pulse when an abort completes
- frame_overrun  out  1  one-cycle pulse when frame_tick arrives while busy

Behaviour:
- Reset values: x=0, y=0, obj_code=0, en_update=0, busy=0, frame_done=0, sync_reset=0, frame_overrun=0, init_cycle=1, state=IDLE. Shadow contents are don't-care because init_cycle forces a full refresh.
- Object encoding, priority head > body > apple > border: 1, 2, 3, 4 respectively; 0 when no flag is set. Values are zero-extended to CODE_W.
- States are IDLE, SCAN, UPDATE, ABORT, DONE.
- IDLE:
  - frame_tick -> SCAN, with x=0, y=0.
  - refresh_frame latches (init_cycle | full_refresh).
- SCAN, one cell per cycle:
  - Compute code from flags; read shadow[x][y].
  - If refresh_frame or code != shadow: obj_code<=code, write shadow[x][y]<=code, en_update<=1, -> UPDATE.
  - Otherwise advance.
- UPDATE:
  - Hold x, y, obj_code and en_update=1 until cmd_done=1.
  - On cmd_done: en_update<=0, then advance. Back-to-back requests therefore have at least one idle cycle between them.
- Advance:
  - If x < GRID_W-1: x++.
  - Else x<=0 and y++.
  - From the last cell (GRID_W-1, GRID_H-1) -> DONE.
- DONE: frame_done=1 for one cycle; if refresh_frame, init_cycle<=0; -> IDLE with x=y=0.
- No-change frame latency: frame_tick to frame_done is GRID_W*GRID_H+2 cycles.
- Abort:
  - A rising edge of game_over or mode_pb (edge detect registered inside the block) sets init_cycle<=1.
  - From SCAN or DONE -> ABORT.
  - From UPDATE: stay until cmd_done, then -> ABORT. A command is never cut mid-transfer.
  - ABORT: sync_reset=1 for one cycle, x=y=0 -> IDLE.
  - An abort edge in IDLE pulses sync_reset on the next cycle.
- frame_tick while busy: ignored; frame_overrun pulses for one cycle.
- A cmd_done pulse outside UPDATE is ignored.
- Asynchronous nrst mid-operation returns to reset values immediately; en_update drops without a handshake.

Decomposition:
- Package map_pkg holds:
  - obj_code_t with OBJ_EMPTY=0, OBJ_HEAD=1, OBJ_BODY=2, OBJ_APPLE=3, OBJ_BORDER=4;
  - default GRID_W/GRID_H constants;
  - the state enum.
- Sub-module map_shadow_ram:
  - GRID_W*GRID_H x CODE_W storage;
  - combinational read, synchronous write;
  - index y*GRID_W+x.

Test Plan:
- Reset, then 5 idle cycles -> x=0, y=0, init_cycle=1, en_update=0, busy=0.
- First frame_tick, border flag on the perimeter cells, head at (4,4), apple at (6,4), cmd_done returned 3 cycles after each request:
  - exactly 192 en_update handshakes in raster order;
  - obj_code=4 on the perimeter, 1 at (4,4), 3 at (6,4), 0 elsewhere;
  - frame_done once; init_cycle=0 afterwards.
- Identical second frame -> no en_update; frame_done exactly 194 cycles after frame_tick.
- Head moves (4,4)->(5,4) and body appears at (4,4) -> exactly 2 requests: (4,4) code 2, then (5,4) code 1.
- Head and body both asserted at (7,4) -> obj_code=1.
- game_over rises while in UPDATE with cmd_done withheld 10 cycles -> en_update held; sync_reset pulses 1 cycle after cmd_done; next frame issues 192 requests.
- frame_tick during SCAN -> frame_overrun pulses once; scan continues unaffected.
